// File: rtl/rr_enc_pkg.sv
// Shared types and helpers for the round-robin 8:3 request encoder.
package rr_enc_pkg;

  localparam int N = 8;
  localparam int W = 3;

  typedef enum logic {IDLE, PRESENT} rr_state_t;

  typedef logic [N-1:0] req_vec_t;
  typedef logic [W-1:0] idx_t;

  function automatic req_vec_t onehot(input idx_t i);
    return req_vec_t'(1) << i;
  endfunction

  // Rotate right by s so that bit s lands in position 0.
  function automatic req_vec_t rotr(input req_vec_t v, input idx_t s);
    logic [2*N-1:0] dbl;
    dbl = {v, v};
    return dbl[s +: N];
  endfunction

endpackage

// File: rtl/priority_encoder8x3.sv
// Fixed-priority 8:3 encoder, bit 0 highest; any flags a non-empty input.
module priority_encoder8x3
  import rr_enc_pkg::*;
(
  input  logic [N-1:0] in,
  output logic [W-1:0] out,
  output logic         any
);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    out = '0;
    any = |in;
    for (int i = N - 1; i >= 0; i--) begin
      if (in[i]) out = W'(i);
    end
  end

endmodule

// File: rtl/rr_encoder8x3.sv
// Round-robin 8:3 request encoder with valid/ready output handshake.
// Optional RR_ENC_ONEHOT_EN adds a registered one-hot grant output.
module rr_encoder8x3
  import rr_enc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] idx,
`ifdef RR_ENC_ONEHOT_EN
  output logic [N-1:0] grant,
`endif
  output logic [N-1:0] pending
);

  rr_state_t state;
  idx_t      ptr;

  logic      fire;
  req_vec_t  cand;
  req_vec_t  rem;
  req_vec_t  pick_vec;
  req_vec_t  rot;
  idx_t      base;
  idx_t      pe_out;
  idx_t      pick;
  logic      pick_any;

  // A fresh pulse on the bit being granted survives as a new event.
  always_comb begin
    fire     = valid & ready;
    cand     = pending | req;
    rem      = (cand & ~onehot(idx)) | (req & onehot(idx));
    pick_vec = fire ? rem : cand;
    base     = fire ? idx + idx_t'(1) : ptr;
    rot      = rotr(pick_vec, base);
  end

  priority_encoder8x3 u_pe (
    .in  (rot),
    .out (pe_out),
    .any (pick_any)
  );

  assign pick = pe_out + base;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= 1'b0;
      idx     <= '0;
      ptr     <= '0;
      pending <= '0;
`ifdef RR_ENC_ONEHOT_EN
      grant   <= '0;
`endif
    end else begin
      pending <= fire ? rem : cand;
      case (state)
        IDLE: begin
          if (pick_any) begin
            idx   <= pick;
            valid <= 1'b1;
            state <= PRESENT;
`ifdef RR_ENC_ONEHOT_EN
            grant <= onehot(pick);
`endif
          end else begin
            valid <= 1'b0;
`ifdef RR_ENC_ONEHOT_EN
            grant <= '0;
`endif
          end
        end
        PRESENT: begin
          if (fire) begin
            ptr <= idx + idx_t'(1);
            if (pick_any) begin
              idx <= pick;
`ifdef RR_ENC_ONEHOT_EN
              grant <= onehot(pick);
`endif
            end else begin
              valid <= 1'b0;
              state <= IDLE;
`ifdef RR_ENC_ONEHOT_EN
              grant <= '0;
`endif
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
